ks16_sum_stage: RTL
===================

// Module: ks16_sum_stage
// PURPOSE
//  Final, pipelined stage of the 16-bit Kogge-Stone adder. Consumes group
//  propagate/generate after the distance-4 prefix layer, applies the last
//  (distance-8) prefix combine and forms carries and sum bits.
//  Two register stages with a valid/ready handshake on both sides.
//  Sits between the distance-4 prefix layer and the adder result consumer.
// PARAMETERS
//  W     16  operand width; only 16 is supported.
//  SPAN   8  final prefix distance; must equal W/2.
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  rst        in   1  synchronous reset, active-high
//  in_valid   in   1  upstream beat present
//  in_ready   out  1  stage can accept a beat this cycle
//  grp_p      in   16 group propagate after distance-4 layer (bit i covers i..max(0,i-7))
//  grp_g      in   16 group generate after distance-4 layer, same span as grp_p
//  half_sum   in   16 per-bit a^b
//  cin        in   1  adder carry-in
//  out_valid  out  1  result beat present
//  out_ready  in   1  downstream accepts result
//  out_sum    out  16 a+b+cin, low 16 bits
//  out_cout   out  1  carry out of bit 15
// BEHAVIOUR
//  - Reset: s1_valid=0, out_valid=0, out_sum=0, out_cout=0; in_ready=1 the cycle after reset.
//    rst overrides any simultaneous transfer; beats in flight are dropped, not output.
//  - Stage 1 (reg): for i>=SPAN: p8[i]=grp_p[i]&grp_p[i-8], g8[i]=grp_g[i]|(grp_p[i]&grp_g[i-8]).
//    For i<SPAN: p8[i]=grp_p[i], g8[i]=grp_g[i]. Also registers half_sum and cin.
//  - Stage 2 (reg): c[0]=cin; c[i]=g8[i-1]|(p8[i-1]&cin) for i=1..15.
//    out_sum=half_sum^c; out_cout=g8[15]|(p8[15]&cin). No truncation beyond 16 bits.
//  - Handshake: transfer when valid&&ready on the same edge.
//    adv2 = !out_valid || out_ready; adv1 = !s1_valid || adv2; in_ready = adv1.
//    in_ready depends only on state and out_ready; it never depends on in_valid.
//  - Stage 1 loads on in_valid&&adv1. s1_valid <= in_valid when adv1, else holds.
//    Stage 2 loads from stage 1 on s1_valid&&adv2. out_valid <= s1_valid when adv2, else holds.
//  - Latency is 2 cycles from accept to out_valid with out_ready high.
//    Throughput is 1 beat/cycle; there are no bubbles under continuous ready.
//  - Backpressure: while out_valid&&!out_ready, out_sum and out_cout stay stable.
//    Stage 1 fills if empty; when both stages are full, in_ready=0.
//  - Simultaneous out transfer and in transfer on a full pipe: both beats move and the pipe stays full.
//  - Data registers load only on transfer; they ignore inputs otherwise.
//  - No FSM beyond the two valid bits. State set {s1_valid,out_valid}: 00 empty, 10, 01, 11 full.
// STRUCTURE
//  - ks_pkg: KS_W=16, KS_SPAN=8 localparams, shared with the other prefix layers and the pg pre-stage.
//  - Sub-module ks_pg_cell, combinational black cell (pi,gi,pj,gj -> po,go).
//    16 instances are generated in stage 1 (pass-through for i<8). The same cell is reused by the other layers.
//  - Carry/sum logic and both pipeline registers stay inline in this module.
// TESTING
//  The bench drives grp_p, grp_g and half_sum from A, B through a behavioural model of layers 0-4.
//  Scoreboard checks A+B+cin.
//  1. A=FFFF B=0001 cin=0, out_ready=1 -> 2 cycles later out_sum=0000 out_cout=1.
//  2. A=7FFF B=0000 cin=1 -> out_sum=8000 out_cout=0. Also A=0000 B=0000 cin=1 -> 0001, cout 0.
//  3. Stream 8 beats back-to-back, out_ready=1 -> in_ready stays 1; 8 results on 8 consecutive cycles, in order.
//  4. out_ready=0, offer 3 beats (1234+1111, 00FF+0001, 8000+8000):
//     2 accepted, in_ready=0, out_sum holds 2345.
//     Then out_ready=1 -> results 2345, 0100, 0000/cout=1 in order.
//  5. Full pipe, pulse rst 1 cycle -> next cycle out_valid=0, out_sum=0, in_ready=1.
//     No stale beat emerges afterward.
//  6. 10k random A,B,cin with random in_valid/out_ready -> zero scoreboard mismatches.
//     No beat loss or duplication. Outputs stable under stall.

Source files
------------

// File: rtl/ks_pkg.sv
// Shared constants and types for the 16-bit Kogge-Stone adder pipeline.
// Used by the pg pre-stage, the prefix layers and the final sum stage.
package ks_pkg;

    localparam int KS_W    = 16;
    localparam int KS_SPAN = 8;

    // Stage-1 payload of the sum stage: fully-combined P/G plus what the sum needs.
    typedef struct packed {
        logic [KS_W-1:0] p;
        logic [KS_W-1:0] g;
        logic [KS_W-1:0] hs;
        logic            cin;
    } ks_s1_t;

    // Carry into every bit given prefix P/G spanning down to bit 0.
    function automatic logic [KS_W-1:0] ks_carries(
        input logic [KS_W-1:0] p,
        input logic [KS_W-1:0] g,
        input logic            cin
    );
        logic [KS_W-1:0] c;
        c[0] = cin;
        for (int i = 1; i < KS_W; i++) begin
            c[i] = g[i-1] | (p[i-1] & cin);
        end
        return c;
    endfunction

endpackage

// File: rtl/ks_pg_cell.sv
// Kogge-Stone black cell: merges a high group (pi,gi) with a lower group (pj,gj).
// Latency: combinational.
// Backpressure: none, pure logic.
module ks_pg_cell (
    input  logic pi,
    input  logic gi,
    input  logic pj,
    input  logic gj,
    output logic po,
    output logic go
);

    assign po = pi & pj;
    assign go = gi | (pi & gj);

endmodule

// File: rtl/ks16_sum_stage.sv
// Final distance-8 prefix combine plus carry/sum formation of the 16-bit KS adder.
// Latency: 2 cycles (stage-1 register, output register), 1 beat/cycle.
// Backpressure: skid-free valid/ready; in_ready falls only when both stages hold beats and out_ready is low.
module ks16_sum_stage
    import ks_pkg::*;
#(
    parameter int W    = KS_W,
    parameter int SPAN = KS_SPAN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] grp_p,
    input  logic [W-1:0] grp_g,
    input  logic [W-1:0] half_sum,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_cout
);

    logic         adv1;
    logic         adv2;
    logic         s1_valid;
    ks_s1_t       s1_dat;
    ks_s1_t       s1_nxt;
    logic [W-1:0] p8;
    logic [W-1:0] g8;
    logic [W-1:0] carry;
    logic [W-1:0] sum_nxt;
    logic         cout_nxt;

    assign adv2     = !out_valid || out_ready;
    assign adv1     = !s1_valid || adv2;
    assign in_ready = adv1;

    // Low half already spans down to bit 0; feeding an identity partner keeps all 16 cells uniform.
    for (genvar i = 0; i < W; i++) begin : g_d8
        if (i >= SPAN) begin : g_cell
            ks_pg_cell u_cell (
                .pi (grp_p[i]),
                .gi (grp_g[i]),
                .pj (grp_p[i-SPAN]),
                .gj (grp_g[i-SPAN]),
                .po (p8[i]),
                .go (g8[i])
            );
        end else begin : g_pass
            ks_pg_cell u_cell (
                .pi (grp_p[i]),
                .gi (grp_g[i]),
                .pj (1'b1),
                .gj (1'b0),
                .po (p8[i]),
                .go (g8[i])
            );
        end
    end

    always_comb begin
        s1_nxt     = '0;
        s1_nxt.p   = p8;
        s1_nxt.g   = g8;
        s1_nxt.hs  = half_sum;
        s1_nxt.cin = cin;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && in_valid && adv1) begin
            s1_dat <= s1_nxt;
        end
    end

    always_comb begin
        carry    = ks_carries(s1_dat.p, s1_dat.g, s1_dat.cin);
        sum_nxt  = s1_dat.hs ^ carry;
        cout_nxt = s1_dat.g[W-1] | (s1_dat.p[W-1] & s1_dat.cin);
    end

    // Output registers hold while stalled so the consumer sees a stable beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
        end else begin
            if (adv2) begin
                out_valid <= s1_valid;
            end
            if (s1_valid && adv2) begin
                out_sum  <= sum_nxt;
                out_cout <= cout_nxt;
            end
        end
    end

endmodule
